// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider.
// State encoding and default operand width.
package seq_divider_pkg;

  localparam int DEF_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor on W+1 bits, keep or restore.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_r,
  input  logic         i_bit,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_r_next,
  output logic         o_q
);

  logic [W:0] w_t;
  logic [W:0] w_d;

  assign w_t = {i_r, i_bit};
  assign w_d = {1'b0, i_div};
  assign o_q = (w_t >= w_d);

  // When the subtract succeeds the result is below the divisor,
  // so the low W bits carry it exactly.
  assign o_r_next = o_q ? (w_t[W-1:0] - i_div)
                        : w_t[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, 2W / W -> W quotient, W remainder.
// One quotient bit per clock, valid/ready on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

  div_state_e r_state;
  div_state_e w_next;

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_dlo;
  logic [W-1:0]  r_div;
  logic [W-1:0]  r_quo;
  logic [CW-1:0] r_cnt;
  logic          r_dz;
  logic          r_ovf;

  logic [W-1:0] w_hi;
  logic [W-1:0] w_lo;
  logic         w_dz;
  logic         w_ovf;
  logic [W-1:0] w_rnext;
  logic         w_qbit;

  assign w_hi  = dividend[2*W-1:W];
  assign w_lo  = dividend[W-1:0];
  assign w_dz  = (divisor == '0);
  assign w_ovf = !w_dz && (w_hi >= divisor);

  div_step #(.W(W)) u_step (
    .i_r      (r_rem),
    .i_bit    (r_dlo[W-1]),
    .i_div    (r_div),
    .o_r_next (w_rnext),
    .o_q      (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid)
          w_next = (w_dz || w_ovf) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == '0) w_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_dlo <= '0;
      r_div <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_dz  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_div <= divisor;
            r_dz  <= w_dz;
            r_ovf <= w_ovf;
            if (w_dz) begin
              r_quo <= '1;
              r_rem <= w_lo;
            end else if (w_ovf) begin
              r_quo <= '1;
              r_rem <= '0;
            end else begin
              r_quo <= '0;
              r_rem <= w_hi;
              r_dlo <= w_lo;
              r_cnt <= CNT_INIT;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rnext;
          r_quo <= {r_quo[W-2:0], w_qbit};
          r_dlo <= {r_dlo[W-2:0], 1'b0};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign div_zero  = r_dz;
  assign overflow  = r_ovf;

endmodule
